// File: rtl/rom_bank_sel.sv
// rom_bank_sel: registered upper-ROM select register and bank read mux for the CPC &DFxx space.
// Optional macro ROMSEL_LOCK_EN adds lock_i / lock_err_o to block writes while the supervisor pins the selection.
`default_nettype none

module rom_bank_sel #(
  parameter int DATA_W   = 8,
  parameter int NUM_ROMS = 16,
  parameter int IDX_W    = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
`ifdef ROMSEL_LOCK_EN
  input  logic                         lock_i,
  output logic                         lock_err_o,
`endif
  input  logic                         wr_i,
  input  logic [7:0]                   wr_d_i,
  input  logic [NUM_ROMS-1:0]          present_i,
  input  logic                         rd_i,
  input  logic [NUM_ROMS*DATA_W-1:0]   d_flat_i,
  output logic [DATA_W-1:0]            d_o,
  output logic                         valid_o,
  output logic [IDX_W-1:0]             sel_o,
  output logic [7:0]                   raw_o
);

  // 9 bits so that NUM_ROMS=256 compares correctly against an 8-bit value.
  localparam logic [8:0] ROM_LIMIT = 9'(NUM_ROMS);

  logic [DATA_W-1:0] banks [NUM_ROMS];
  logic              in_range;
  logic              fitted;
  logic              wr_en;
  logic [IDX_W-1:0]  mapped_sel;

  for (genvar n = 0; n < NUM_ROMS; n++) begin : g_unpack
    assign banks[n] = d_flat_i[n*DATA_W +: DATA_W];
  end

  always_comb begin
    in_range   = ({1'b0, wr_d_i} < ROM_LIMIT);
    fitted     = present_i[wr_d_i[IDX_W-1:0]];
    mapped_sel = (in_range && fitted) ? wr_d_i[IDX_W-1:0] : '0;
`ifdef ROMSEL_LOCK_EN
    wr_en      = wr_i && !lock_i;
`else
    wr_en      = wr_i;
`endif
  end

  // Read uses the pre-edge sel_o, so a same-cycle write affects only later reads.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      d_o     <= '0;
      valid_o <= 1'b0;
      sel_o   <= '0;
      raw_o   <= '0;
    end else begin
      valid_o <= rd_i;
      if (rd_i) begin
        d_o <= banks[sel_o];
      end
      if (wr_en) begin
        raw_o <= wr_d_i;
        sel_o <= mapped_sel;
      end
    end
  end

`ifdef ROMSEL_LOCK_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lock_err_o <= 1'b0;
    end else begin
      lock_err_o <= wr_i && lock_i;
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/rom_bank_sel.md
Name: rom_bank_sel

Overview:
- Parametrised, registered successor to the combinational ROM selector for the CPC upper-ROM space.
- Holds the upper-ROM select register, written by the Z80 I/O decode on an OUT to &DFxx.
- Maps absent or out-of-range ROM numbers to ROM 0 (BASIC fallback).
- Returns read data from the selected bank one clock after a read request, with a valid strobe. It sits between the I/O decode / memory arbiter and the per-bank ROM data sources.

Parameters:
- DATA_W, 8: width of each ROM data bus.
- NUM_ROMS, 16: number of bank inputs; power of two, 2..256.
- IDX_W, 4: width of the bank index; must equal log2(NUM_ROMS).

Ports:
- clk_i  in  1  system clock; all state is updated on the rising edge.
- rst_n_i  in  1  asynchronous reset, active low.
- wr_i  in  1  single-cycle strobe: write the select register.
- wr_d_i  in  8  value written by the Z80 (ROM number 0..255).
- present_i  in  NUM_ROMS  bit n set = bank n is fitted.
- rd_i  in  1  single-cycle read request.
- d_flat_i  in  NUM_ROMS*DATA_W  bank n data at bits [n*DATA_W +: DATA_W].
- d_o  out  DATA_W  registered read data.
- valid_o  out  1  one-cycle strobe: d_o is valid.
- sel_o  out  IDX_W  effective (mapped) bank index.
- raw_o  out  8  last value written, unmapped.

Behaviour:
- Reset (async assert, synchronous-safe deassert): d_o=0, valid_o=0, sel_o=0, raw_o=0.
- Write mapping: on a clock with wr_i=1:
  - raw_o <= wr_d_i.
  - sel_o <= wr_d_i[IDX_W-1:0] only if wr_d_i < NUM_ROMS and present_i[wr_d_i] = 1; otherwise sel_o <= 0.
  - Widths: compare wr_d_i as 8-bit unsigned against NUM_ROMS. When NUM_ROMS=256 every value is in range.
- Mapping is evaluated only at write time. A later change of present_i does not alter sel_o until the next write.
- Read: on a clock with rd_i=1, d_o <= bank[sel_o] using the sel_o value before this edge, and valid_o <= 1. Latency is 1 clock.
- valid_o is 1 only for the cycle after each rd_i. Back-to-back rd_i gives back-to-back valid_o; there is no throughput limit.
- When rd_i=0, d_o holds its last value and valid_o = 0.
- Simultaneous wr_i and rd_i: the read uses the OLD selection and the write takes effect from the following clock.
- Consecutive writes: last write wins, one per clock. There is no queuing.
- Reset mid-operation: a pending valid_o is cleared immediately and the selection returns to bank 0.
- Bank 0 is always readable regardless of present_i[0].

Optional Feature:
- Macro: ROMSEL_LOCK_EN.
- With the macro defined:
  - Adds input lock_i (1) and output lock_err_o (1), reset 0.
  - While lock_i = 1, a write is ignored (raw_o and sel_o unchanged) and lock_err_o pulses 1 for the following cycle.
  - Reads are unaffected.
  - Used by the supervisor to pin the BASIC/AMSDOS selection during boot.
- Without the macro: neither port exists and every write is accepted.

Test Plan:
- Reset then rd_i pulse with d_flat_i bank0=8'hA5 -> next cycle valid_o=1, d_o=8'hA5; sel_o=0, raw_o=0.
- present_i=16'h0081, write 8'h07, rd next cycle with bank7=8'h3C -> sel_o=7, raw_o=8'h07, d_o=8'h3C one cycle after rd_i.
- present_i=16'h0081, write 8'h05 (absent), then write 8'h20 (out of range) -> sel_o=0 both times, raw_o=8'h05 then 8'h20; reads return bank0 data.
- sel_o=7, same-cycle wr_i=8'h00 and rd_i -> d_o=bank7 data; following rd_i returns bank0 data.
- Write 8'h07 with present_i[7]=1, then clear present_i[7], read -> still bank7 data. Assert rst_n_i=0 mid-read -> valid_o=0 and sel_o=0 immediately.
- ROMSEL_LOCK_EN: sel_o=7, lock_i=1, write 8'h00 -> sel_o stays 7, lock_err_o=1 for exactly one cycle. With lock_i=0 the same write gives sel_o=0.
